// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit: request latch, size/alignment check, lane steering, load extension
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd_strobe,
  output logic [3:0]  mem_wr_strobe,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, LOAD, RESP} state_t;

  state_t      state, next_state;
  logic        accept;
  logic        req_err;
  logic [3:0]  req_strb;
  logic [31:0] req_lanes;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  strb_q;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Alignment and legality are judged on the live request so the error path needs no extra cycle.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = (req_addr[1:0] != 2'b00);
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we || req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    req_strb  = 4'b1111;
    req_lanes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_strb  = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_strb  = 4'b0011 << req_addr[1:0];
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        req_strb  = 4'b1111;
        req_lanes = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = req_err ? RESP : ISSUE;
      ISSUE:   next_state = we_q ? RESP : LOAD;
      LOAD:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Memory-facing address/data only move on a legal accept, so they hold across errors and idle time.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      strb_q    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else if (accept && !req_err) begin
      we_q      <= req_we;
      funct3_q  <= req_funct3;
      off_q     <= req_addr[1:0];
      strb_q    <= req_strb;
      mem_addr  <= {req_addr[31:2], 2'b00};
      mem_wdata <= req_lanes;
    end
  end

  assign mem_rd_strobe = (state == ISSUE) && !we_q;
  assign mem_wr_strobe = ((state == ISSUE) && we_q) ? strb_q : 4'b0000;

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Response registers are written on the edge entering RESP and then hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (accept && req_err) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b1;
    end else if ((state == ISSUE) && we_q) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (state == LOAD) begin
      resp_rdata <= load_ext;
      resp_err   <= 1'b0;
    end
  end

  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-level reference memory
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd_strobe;
  logic [3:0]  mem_wr_strobe;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_strobe(mem_rd_strobe),
    .mem_wr_strobe(mem_wr_strobe), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] env_mem [64];
  logic [31:0] ref_mem [64];

  always @(posedge clk) begin
    if (mem_rd_strobe) mem_rdata <= env_mem[mem_addr[7:2]];
    for (int i = 0; i < 4; i++)
      if (mem_wr_strobe[i]) env_mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  typedef struct { logic [31:0] rdata; logic err; int due; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } mop_t;
  resp_t resp_q[$];
  mop_t  mop_q[$];

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int last_resp_cyc = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, ncyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, ncyc);
  endtask

  function automatic logic model_err(input logic we, input logic [31:0] a, input logic [2:0] f);
    case (f)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return we;
      3'b101:  return we || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic int size_of(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    logic [31:0] v;
    int n;
    w = ref_mem[a[7:2]] >> (8 * int'(a[1:0]));
    n = size_of(f);
    v = (n == 4) ? w : (w & ((32'h1 << (8 * n)) - 1));
    if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  always @(negedge clk) begin
    mop_t m;
    resp_t r;
    ncyc++;
    if (mon_on) begin
      if (mem_rd_strobe && mem_wr_strobe != 4'b0000) fail_now("both_strobes");
      if (mem_rd_strobe || mem_wr_strobe != 4'b0000) begin
        if (mop_q.size() == 0) fail_now("unexpected_mem_op");
        else begin
          m = mop_q.pop_front();
          chk("mem_rd_strobe", {31'h0, mem_rd_strobe}, {31'h0, !m.we});
          chk("mem_wr_strobe", {28'h0, mem_wr_strobe}, {28'h0, (m.we ? m.strb : 4'b0000)});
          chk("mem_addr", mem_addr, m.addr);
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) fail_now("unexpected_resp_valid");
        else begin
          r = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
          chk("resp_latency", ncyc, r.due);
          last_resp_cyc = ncyc;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f, input logic keep, output int acc);
    logic found;
    logic e;
    int n;
    mop_t m;
    resp_t r;
    found = 1'b0;
    acc = -1;
    for (int w = 0; w < 50 && !found; w++) begin
      @(negedge clk);
      #1;
      if (req_ready) found = 1'b1;
    end
    if (!found) begin
      fail_now("req_ready_timeout");
      req_valid = 1'b0;
      return;
    end
    req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f; req_valid = 1'b1;
    acc = ncyc;
    e = model_err(we, a, f);
    r.err = e;
    r.rdata = (e || we) ? 32'h0 : model_load(a, f);
    r.due = acc + (e ? 1 : (we ? 2 : 3));
    if (!e) begin
      n = size_of(f);
      m.we = we; m.addr = {a[31:2], 2'b00}; m.strb = 4'b0000; m.wdata = 32'h0;
      for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
      if (we)
        for (int k = 0; k < n; k++) begin
          m.strb[int'(a[1:0]) + k] = 1'b1;
          ref_mem[a[7:2]][8*(int'(a[1:0]) + k) +: 8] = wd[8*k +: 8];
        end
      mop_q.push_back(m);
    end
    resp_q.push_back(r);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int acc2;
    logic [31:0] a;
    logic [2:0] f;
    logic [2:0] ftab [8];
    ftab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b001, 3'b011};
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;

    @(posedge clk); #1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_strobes", {27'h0, mem_rd_strobe, mem_wr_strobe}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b0, acc);
    issue(1'b1, 32'h10, 32'h80123456, 3'b010, 1'b0, acc);
    issue(1'b0, 32'h13, 32'h0, 3'b000, 1'b0, acc);
    issue(1'b0, 32'h13, 32'h0, 3'b100, 1'b0, acc);
    issue(1'b0, 32'h12, 32'h0, 3'b101, 1'b0, acc);
    issue(1'b1, 32'h21, 32'h000000A5, 3'b000, 1'b0, acc);
    issue(1'b0, 32'h20, 32'h0, 3'b010, 1'b0, acc);
    issue(1'b1, 32'h22, 32'h0000BEEF, 3'b001, 1'b0, acc);
    issue(1'b0, 32'h06, 32'h0, 3'b010, 1'b0, acc);
    issue(1'b1, 32'h24, 32'h12345678, 3'b100, 1'b0, acc);
    issue(1'b0, 32'h25, 32'h0, 3'b111, 1'b0, acc);

    issue(1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 1'b1, acc);
    issue(1'b0, 32'h30, 32'h0, 3'b010, 1'b0, acc2);
    chk("b2b_accept_cycle", acc2, acc + 3);

    issue(1'b0, 32'h40, 32'h0, 3'b010, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    void'(resp_q.pop_back());
    @(negedge clk);
    #1;
    chk("rst_mid_ready_low", {31'h0, req_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("post_rst_strobes", {27'h0, mem_rd_strobe, mem_wr_strobe}, 32'h0);
    issue(1'b0, 32'h40, 32'h0, 3'b010, 1'b0, acc);

    for (int t = 0; t < 300; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:8] = 24'h0;
      f = ftab[$urandom_range(0, 7)];
      issue(1'($urandom_range(0, 1)), a, $urandom, f, 1'($urandom_range(0, 1)), acc);
    end
    req_valid = 1'b0;

    for (int w = 0; w < 100 && (resp_q.size() != 0 || mop_q.size() != 0); w++) @(negedge clk);
    chk("drain_resp_q", resp_q.size(), 32'h0);
    chk("drain_mop_q", mop_q.size(), 32'h0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at RV32 values.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  high iff state IDLE and rst low; a request SHALL be accepted on an edge where req_valid and req_ready are both high.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  aligned, extended load result; 0 for stores and errors.
REQ-012 resp_err  output  1  misaligned or illegal request; valid with resp_valid.
REQ-013 mem_addr  output  32  word address to memory, {addr[31:2],2'b00}.
REQ-014 mem_wdata  output  32  lane-replicated store data.
REQ-015 mem_rd_strobe  output  1  memory read enable; memory returns data on mem_rdata in the next cycle.
REQ-016 mem_wr_strobe  output  4  per-byte write enables; bit n writes byte lane n at the next edge.
REQ-017 mem_rdata  input  32  registered memory read data.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, LOAD, RESP; all request fields SHALL be latched at acceptance and the core need not hold them afterwards.
REQ-019 Error detection at acceptance: H/HU with addr[0]=1, W with addr[1:0]!=0, funct3 in {011,110,111}, or store with funct3 in {100,101}.
REQ-020 On an error the FSM SHALL go IDLE->RESP, assert no memory strobe, and respond with resp_err=1 and resp_rdata=0.
REQ-021 Otherwise the FSM SHALL go IDLE->ISSUE; in ISSUE the mem_* outputs are driven from the latched request for exactly one cycle.
REQ-022 Load sequence: ISSUE (mem_rd_strobe=1) -> LOAD (mem_rdata captured at the end of the cycle) -> RESP.
REQ-023 Store sequence: ISSUE (mem_wr_strobe nonzero) -> RESP.
REQ-024 Latency from the accept edge: load resp_valid in the 3rd cycle after; store in the 2nd; error in the 1st.
REQ-025 In RESP, resp_valid=1 for exactly one cycle, then the FSM SHALL return to IDLE; back-to-back requests are accepted on the next IDLE cycle.
REQ-026 Store strobes: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
REQ-027 Store data: B replicates wdata[7:0] into all four lanes; H replicates wdata[15:0] into both halves; W passes wdata through unchanged.
REQ-028 Load extraction: shifted = mem_rdata >> (8*addr[1:0]).
REQ-029 Load extension: B sign-extends shifted[7:0]; BU zero-extends it; H sign-extends shifted[15:0]; HU zero-extends it; W uses shifted.
REQ-030 Outside ISSUE, mem_rd_strobe and mem_wr_strobe SHALL be 0; mem_addr and mem_wdata hold their last values.
REQ-031 resp_rdata and resp_err SHALL hold their values until the next RESP.
REQ-032 mem_rd_strobe and mem_wr_strobe SHALL never both be nonzero in the same cycle.

Reset
REQ-033 On rst: state=IDLE; resp_valid, resp_err, mem_rd_strobe=0; mem_wr_strobe=0000; resp_rdata, mem_addr, mem_wdata=0.
REQ-034 rst asserted in any state SHALL abort the operation: strobes are 0 from the next cycle, no resp_valid is produced for the aborted request, and req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-035 LW addr 0x10, memory word 0x8899AABB -> one cycle with mem_rd_strobe=1 and mem_addr=0x10; resp_valid 3 cycles after accept; resp_rdata=0x8899AABB; resp_err=0.
REQ-036 LB addr 0x13, word 0x80123456 -> resp_rdata=0xFFFFFF80; LBU same address -> 0x00000080; LHU addr 0x12 -> 0x00008012.
REQ-037 SB addr 0x21, wdata 0x000000A5 -> mem_wr_strobe=0010, mem_wdata=0xA5A5A5A5, mem_addr=0x20; resp_valid 2 cycles after accept; a follow-up LW reads back byte 1 = 0xA5.
REQ-038 SH addr 0x22 -> strobe 1100; LW addr 0x06 -> resp_err=1 one cycle after accept, no strobes; SBU (store with funct3 100) -> resp_err=1.
REQ-039 Back-to-back SW then LW to the same address with req_valid held high -> second request accepted on the first IDLE cycle after RESP; read returns the stored word.
REQ-040 rst pulsed during LOAD -> no resp_valid, strobes 0, req_ready=1 on the first cycle after rst falls, and the next LW completes normally.
